// File: rtl/serial_add_pkg.sv
// ============================================================================
// serial_add_pkg : shared types/constants for the digit-serial adder
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

    localparam int DIGIT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Digit counter width; never below one bit.
    function automatic int cnt_width(input int width);
        int n;
        n = width / DIGIT_WIDTH;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/carry_skip_adder_4bit.sv
// ============================================================================
// carry_skip_adder_4bit : 4-bit ripple adder with block carry-skip
// Rev 1.0
// ============================================================================
`default_nettype none

module carry_skip_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic       w_c1;
    logic       w_c2;
    logic       w_c3;
    logic       w_c4;

    assign w_p  = a ^ b;
    assign w_g  = a & b;
    assign w_c1 = w_g[0] | (w_p[0] & carry_in);
    assign w_c2 = w_g[1] | (w_p[1] & w_c1);
    assign w_c3 = w_g[2] | (w_p[2] & w_c2);
    assign w_c4 = w_g[3] | (w_p[3] & w_c3);

    assign sum = w_p ^ {w_c3, w_c2, w_c1, carry_in};
    // When every bit propagates, the incoming carry bypasses the ripple chain.
    assign carry_out = (&w_p) ? carry_in : w_c4;

endmodule

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
// serial_add_sequencer : multi-precision add/sub over one shared 4-bit adder
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    input  logic             carry_in,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int N     = WIDTH / DIGIT_WIDTH;
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N - 1);

    if (((WIDTH % DIGIT_WIDTH) != 0) || (WIDTH < 8)) begin : g_width_check
        $fatal(1, "serial_add_sequencer: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_carry_out;
    logic             r_overflow;
    logic [3:0]       w_digit_sum;
    logic             w_digit_carry;
    logic             w_accept;
    logic             w_last;

    carry_skip_adder_4bit u_adder (
        .a         (r_a[DIGIT_WIDTH-1:0]),
        .b         (r_b[DIGIT_WIDTH-1:0]),
        .carry_in  (r_carry),
        .sum       (w_digit_sum),
        .carry_out (w_digit_carry)
    );

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == C_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Subtraction is left + ~right + 1: invert B at capture and force carry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= left;
            r_b     <= subtract ? ~right : right;
            r_carry <= subtract | carry_in;
            r_cnt   <= '0;
            r_a_msb <= left[WIDTH-1];
            r_b_msb <= right[WIDTH-1] ^ subtract;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT_WIDTH;
            r_b     <= r_b >> DIGIT_WIDTH;
            r_sum   <= {w_digit_sum, r_sum[WIDTH-1:DIGIT_WIDTH]};
            r_carry <= w_digit_carry;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_carry_out <= w_digit_carry;
                r_overflow  <= (r_a_msb == r_b_msb) && (w_digit_sum[3] != r_a_msb);
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// ============================================================================
// tb_serial_add_sequencer : scoreboard bench with an arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_sequencer;

    localparam int WIDTH = 16;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b0;
    logic              in_valid  = 1'b0;
    logic              carry_in  = 1'b0;
    logic              subtract  = 1'b0;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  left      = '0;
    logic [WIDTH-1:0]  right     = '0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  sum;
    logic              carry_out;
    logic              overflow;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    exp_t hold_e;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;

    serial_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .left      (left),
        .right     (right),
        .carry_in  (carry_in),
        .subtract  (subtract),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    // Plain integer arithmetic: unsigned range gives carry, signed range gives overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                                   input logic cin, input logic sub);
        longint ul, ur, sl, sr, full, sfull;
        exp_t   e;
        ul = longint'(l);
        ur = longint'(r);
        sl = longint'($signed(l));
        sr = longint'($signed(r));
        if (sub) begin
            full  = ul - ur;
            sfull = sl - sr;
            e.c   = (ul >= ur);
        end else begin
            full  = ul + ur + longint'(cin);
            sfull = sl + sr + longint'(cin);
            e.c   = (full >= 65536);
        end
        e.s = full[WIDTH-1:0];
        e.o = (sfull > 32767) || (sfull < -32768);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sum", 32'(sum), 32'(mon_e.s));
                check("carry_out", 32'(carry_out), 32'(mon_e.c));
                check("overflow", 32'(overflow), 32'(mon_e.o));
            end
        end
    end

    always @(posedge clock) begin
        if (rand_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                         input logic cin, input logic sub);
        bit done;
        done = 1'b0;
        @(negedge clock);
        left     = l;
        right    = r;
        carry_in = cin;
        subtract = sub;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (in_ready) begin
                sb.push_back(model(l, r, cin, sub));
                @(posedge clock);
                #1 in_valid = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            check("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clock);
            #1 n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clock);
            #1 n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;

        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // First operation: latency and return to IDLE
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_valid(n);
        check("latency", 32'(n), 32'd4);
        check("in_ready_done", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("out_valid_clear", 32'(out_valid), 32'd0);

        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue(16'h0000, 16'h0000, 1'b0, 1'b1);
        drain();

        // Backpressure: result must hold while new requests are refused
        out_ready = 1'b0;
        issue(16'hABCD, 16'h1357, 1'b1, 1'b0);
        wait_valid(n);
        check("bp_valid", 32'(out_valid), 32'd1);
        hold_e = sb[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            left     = 16'($urandom);
            right    = 16'($urandom);
            subtract = 1'($urandom);
            in_valid = 1'b1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'(hold_e.s));
            check("bp_carry", 32'(carry_out), 32'(hold_e.c));
            check("bp_ovf", 32'(overflow), 32'(hold_e.o));
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        check("bp_no_accept", 32'(in_ready), 32'd1);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Random operations with random consumer stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clock);
        #2 out_ready = 1'b1;
        drain();

        // Reset during the second RUN cycle aborts the operation
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        sb.delete();
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_carry", 32'(carry_out), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1 check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
